// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle arithmetic/logic/compare ops with a registered result,
// plus iterative unsigned multiply, divide and remainder taking WIDTH cycles.
module alu_iter #(
   parameter int  WIDTH = 32,
   parameter int  TAG_W = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_cmd,
   input  logic [WIDTH-1:0] in_lhs,
   input  logic [WIDTH-1:0] in_rhs,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz,
   output logic             busy
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
      OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
      OP_EQ   = 5'd8,  OP_NE   = 5'd9,  OP_LT   = 5'd10, OP_LTU  = 5'd11,
      OP_GE   = 5'd12, OP_GEU  = 5'd13, OP_MUL  = 5'd14, OP_DIVU = 5'd15,
      OP_REMU = 5'd16
   } op_e;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state;
   logic [4:0]       it_cmd;
   logic [WIDTH:0]   acc;    // product accumulator / partial remainder
   logic [WIDTH-1:0] opb;    // multiplier / dividend-then-quotient
   logic [WIDTH-1:0] opc;    // multiplicand / divisor
   logic [SHW-1:0]   cnt;
   logic [TAG_W-1:0] it_tag;
   logic             it_dz;

   logic             accept;
   logic             is_iter;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   step_a;
   logic [WIDTH-1:0] step_b;
   logic [WIDTH-1:0] step_c;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Reset is folded in so the requester never sees ready while the block is held in reset.
   assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_iter  = (in_cmd == OP_MUL) || (in_cmd == OP_DIVU) || (in_cmd == OP_REMU);
   assign busy     = (state == BUSY);

   // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      alu_res = '0;
      case (in_cmd)
         OP_ADD:  alu_res = in_lhs + in_rhs;
         OP_SUB:  alu_res = in_lhs - in_rhs;
         OP_AND:  alu_res = in_lhs & in_rhs;
         OP_OR:   alu_res = in_lhs | in_rhs;
         OP_XOR:  alu_res = in_lhs ^ in_rhs;
         OP_SLL:  alu_res = in_lhs << in_rhs[SHW-1:0];
         OP_SRL:  alu_res = in_lhs >> in_rhs[SHW-1:0];
         OP_SRA:  alu_res = $signed(in_lhs) >>> in_rhs[SHW-1:0];
         OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, in_lhs == in_rhs};
         OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, in_lhs != in_rhs};
         OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_lhs) <  $signed(in_rhs)};
         OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, in_lhs <  in_rhs};
         OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_lhs) >= $signed(in_rhs)};
         OP_GEU:  alu_res = {{(WIDTH-1){1'b0}}, in_lhs >= in_rhs};
         default: alu_res = '0;
      endcase
   end

   // One shift-add or restoring-division step. A zero divisor always "succeeds",
   // which yields an all-ones quotient and leaves the dividend as the remainder.
   always_comb begin
      step_a  = acc;
      step_b  = opb;
      step_c  = opc;
      shifted = {acc[WIDTH-1:0], opb[WIDTH-1]};
      trial   = shifted - {1'b0, opc};
      if (it_cmd == OP_MUL) begin
         if (opb[0]) step_a = acc + {1'b0, opc};
         step_b = opb >> 1;
         step_c = opc << 1;
      end else begin
         step_a = trial[WIDTH] ? shifted : trial;
         step_b = {opb[WIDTH-2:0], ~trial[WIDTH]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_tag   <= '0;
         out_dz    <= 1'b0;
         it_cmd    <= '0;
         acc       <= '0;
         opb       <= '0;
         opc       <= '0;
         cnt       <= '0;
         it_tag    <= '0;
         it_dz     <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_iter) begin
                     state  <= BUSY;
                     it_cmd <= in_cmd;
                     it_tag <= in_tag;
                     it_dz  <= (in_cmd != OP_MUL) && (in_rhs == '0);
                     acc    <= '0;
                     opb    <= in_lhs;
                     opc    <= in_rhs;
                     cnt    <= '0;
                  end else begin
                     out_valid <= 1'b1;
                     out_res   <= alu_res;
                     out_tag   <= in_tag;
                     out_dz    <= 1'b0;
                  end
               end
            end
            BUSY: begin
               acc <= step_a;
               opb <= step_b;
               opc <= step_c;
               cnt <= cnt + 1'b1;
               // The output slot is free here: acceptance required it empty or draining.
               if (cnt == SHW'(WIDTH - 1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  out_res   <= (it_cmd == OP_DIVU) ? step_b : step_a[WIDTH-1:0];
                  out_tag   <= it_tag;
                  out_dz    <= it_dz;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: the driver pushes reference results on acceptance,
// a negedge monitor pops and compares every consumed output.
module tb_alu_iter;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_cmd;
   logic [W-1:0]  in_lhs;
   logic [W-1:0]  in_rhs;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_res;
   logic [TW-1:0] out_tag;
   logic          out_dz;
   logic          busy;

   alu_iter #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cmd    (in_cmd),
      .in_lhs    (in_lhs),
      .in_rhs    (in_rhs),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_tag   (out_tag),
      .out_dz    (out_dz),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      logic          dz;
   } exp_t;

   exp_t sb[$];
   exp_t popped;
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   busy_cycles = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [4:0] cmd, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [TW-1:0] tag);
      exp_t e;
      logic [4:0] sh;
      sh    = b[4:0];
      e.tag = tag;
      e.dz  = 1'b0;
      case (cmd)
         5'd0:  e.res = a + b;
         5'd1:  e.res = a - b;
         5'd2:  e.res = a & b;
         5'd3:  e.res = a | b;
         5'd4:  e.res = a ^ b;
         5'd5:  e.res = a << sh;
         5'd6:  e.res = a >> sh;
         5'd7:  e.res = W'($signed(a) >>> sh);
         5'd8:  e.res = W'(a == b);
         5'd9:  e.res = W'(a != b);
         5'd10: e.res = W'($signed(a) < $signed(b));
         5'd11: e.res = W'(a < b);
         5'd12: e.res = W'($signed(a) >= $signed(b));
         5'd13: e.res = W'(a >= b);
         5'd14: e.res = a * b;
         5'd15: begin e.dz = (b == 0); e.res = (b == 0) ? '1 : a / b; end
         5'd16: begin e.dz = (b == 0); e.res = (b == 0) ? a : a % b; end
         default: e.res = '0;
      endcase
      return e;
   endfunction

   // Monitor: a result is consumed at the next rising edge whenever valid and ready are both high.
   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {32'd0, out_res}, 64'hDEAD_0000_0000_0000);
         end else begin
            popped = sb.pop_front();
            check("out_res", {32'd0, out_res}, {32'd0, popped.res});
            check("out_tag", {60'd0, out_tag}, {60'd0, popped.tag});
            check("out_dz",  {63'd0, out_dz},  {63'd0, popped.dz});
         end
      end
   end

   task automatic send(input logic [4:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int waits);
      waits    = 0;
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_lhs   = a;
      in_rhs   = b;
      in_tag   = tag;
      @(negedge clk);
      while (!in_ready && waits < 1000) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         sb.push_back(model(cmd, a, b, tag));
      end
      @(posedge clk);
      #1;
      // Scramble the payload after acceptance: the in-flight op must not see it.
      in_valid = 1'b0;
      in_cmd   = 5'($urandom);
      in_lhs   = $urandom;
      in_rhs   = $urandom;
      in_tag   = TW'($urandom);
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         guard++;
         @(posedge clk);
      end
      #1;
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w;
      int total;
      int b0;
      logic [4:0] cmd;
      logic [W-1:0] a;
      logic [W-1:0] b;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_cmd    = '0;
      in_lhs    = '0;
      in_rhs    = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      check("rst_out_res",   {32'd0, out_res},   64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Wraparound add and SRA with upper shift bits ignored.
      send(5'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, w);
      send(5'd7, 32'h8000_0000, 32'h21, 4'd4, w);

      // Multiply occupies the block for exactly WIDTH cycles; a held request waits it out.
      b0 = busy_cycles;
      send(5'd14, 32'h0001_0003, 32'h0002_0005, 4'd7, w);
      send(5'd0, 32'd1, 32'd2, 4'd8, w);
      check("mul_ready_low_cycles", 64'(w), 64'd32);
      check("mul_busy_cycles", 64'(busy_cycles - b0), 64'd32);

      send(5'd15, 32'd100, 32'd7, 4'd1, w);
      send(5'd16, 32'd100, 32'd7, 4'd2, w);
      send(5'd15, 32'd5,   32'd0, 4'd5, w);
      send(5'd16, 32'd5,   32'd0, 4'd6, w);
      wait_drain();

      // Backpressure: the EQ result must hold while the consumer stalls.
      out_ready = 1'b0;
      send(5'd8, 32'd5, 32'd5, 4'd9, w);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_valid",    {63'd0, out_valid}, 64'd1);
         check("hold_res",      {32'd0, out_res},   64'd1);
         check("hold_tag",      {60'd0, out_tag},   64'd9);
         check("hold_in_ready", {63'd0, in_ready},  64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(5'd10, 32'hFFFF_FFFF, 32'd0, 4'd10, w);
      check("drain_accept_wait", 64'(w), 64'd0);
      check("no_gap_valid", {63'd0, out_valid}, 64'd1);
      check("no_gap_tag",   {60'd0, out_tag},   64'd10);
      wait_drain();

      // Streaming single-cycle ops, occasionally illegal opcodes.
      total = 0;
      for (int i = 0; i < 16; i++) begin
         cmd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 13));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         send(cmd, a, b, TW'(i), w);
         total += w;
      end
      check("stream_stall_cycles", 64'(total), 64'd0);
      send(5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 4'd11, w);

      // A few random iterative ops, including zero divisors.
      for (int i = 0; i < 6; i++) begin
         cmd = 5'($urandom_range(14, 16));
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 999)) : $urandom);
         send(cmd, a, b, TW'(i + 3), w);
      end
      wait_drain();

      // Reset in the middle of a divide: outputs clear at once and nothing stale emerges.
      send(5'd15, 32'd1000, 32'd3, 4'd12, w);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_busy",      {63'd0, busy},      64'd0);
      check("midrst_in_ready",  {63'd0, in_ready},  64'd0);
      check("midrst_out_res",   {32'd0, out_res},   64'd0);
      check("midrst_out_tag",   {60'd0, out_tag},   64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_midrst", {63'd0, in_ready}, 64'd1);
      repeat (40) @(posedge clk);
      #1;
      check("no_stale_valid", {63'd0, out_valid}, 64'd0);
      send(5'd0, 32'd2, 32'd2, 4'd13, w);
      wait_drain();
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
